step_ramp_seq: RTL and testbench

Trapezoidal step-rate sequencer for the stepper drive. On a start command it issues a fixed number of step pulses. The step period starts at DIV_START clocks and shortens by T_STEP per step down to DIV_MIN, then lengthens symmetrically so the move ends at low speed. It exposes the current divide count for the divider path, and sits between the operator/command logic and the motor phase driver.

---
 rtl/step_ramp_seq_if.sv | 23 ++
 rtl/step_ramp_seq.sv | 128 ++++++++++++
 tb/tb_step_ramp_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/step_ramp_seq_if.sv
// Command/status bundle between the operator logic (master) and the step-rate
// sequencer (slave). The motor phase driver consumes step/dir from the same bundle.
interface step_ramp_seq_if;
  logic        start;
  logic        stop;
  logic        dir_in;
  logic [31:0] steps;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] div;

  modport master (
    output start, stop, dir_in, steps,
    input  step, dir, busy, done, div
  );

  modport slave (
    input  start, stop, dir_in, steps,
    output step, dir, busy, done, div
  );
endinterface

// File: rtl/step_ramp_seq.sv
// Trapezoidal step-rate sequencer: accelerates from DIV_START down to DIV_MIN,
// cruises, then decelerates symmetrically so a move of 'steps' pulses ends slowly.
module step_ramp_seq #(
    parameter logic [31:0] DIV_START = 32'd250000,
    parameter logic [31:0] DIV_MIN   = 32'd25000,
    parameter logic [31:0] T_STEP    = 32'd1000
) (
    input  logic             clk,
    input  logic             xres,
    step_ramp_seq_if.slave   bus,
    output logic [1:0]       state_dbg
);

    // Command protocol: start is a level sampled every clock and is accepted
    // only while busy=0; stop is sampled only while busy=1. No ready/ack is
    // returned other than busy rising (accepted move) or done (zero-length move).
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEL = 2'd1, CRUISE = 2'd2, DECEL = 2'd3} state_t;

    localparam logic [32:0] ACC_FLOOR = {1'b0, DIV_MIN} + {1'b0, T_STEP};

    state_t      state_q, state_d;
    logic [31:0] remain_q, remain_d;
    logic [31:0] ramp_q, ramp_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;
    logic        dir_q, dir_d;
    logic        stop_pend_q, stop_pend_d;
    logic        step_q, step_d;
    logic        done_q, done_d;

    logic [32:0] div_sum;
    logic [31:0] div_up;
    logic [31:0] rn;
    logic [31:0] rn_eff;

    assign div_sum = {1'b0, div_q} + {1'b0, T_STEP};
    assign div_up  = (div_sum > {1'b0, DIV_START}) ? DIV_START : div_sum[31:0];
    assign rn      = remain_q - 32'd1;
    // A pending stop limits the remaining steps to what the decel ramp needs.
    assign rn_eff  = (stop_pend_q && (ramp_q < rn)) ? ramp_q : rn;

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            ramp_q      <= '0;
            cnt_q       <= '0;
            div_q       <= DIV_START;
            dir_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            ramp_q      <= ramp_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            dir_q       <= dir_d;
            stop_pend_q <= stop_pend_d;
            step_q      <= step_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        ramp_d      = ramp_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        dir_d       = dir_q;
        stop_pend_d = stop_pend_q;
        step_d      = 1'b0;
        done_d      = 1'b0;

        if (state_q == IDLE) begin
            if (bus.start) begin
                if (bus.steps != 32'd0) begin
                    remain_d    = bus.steps;
                    dir_d       = bus.dir_in;
                    div_d       = DIV_START;
                    cnt_d       = DIV_START;
                    ramp_d      = '0;
                    stop_pend_d = 1'b0;
                    state_d     = ACCEL;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q - 32'd1;
            if (bus.stop) stop_pend_d = 1'b1;
            if (cnt_q == 32'd1) begin
                step_d   = 1'b1;
                remain_d = rn_eff;
                // A stop arriving on this edge survives to the next step edge.
                stop_pend_d = bus.stop;
                if (rn_eff == 32'd0) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                end else if ((state_q == DECEL) || (rn_eff <= ramp_q)) begin
                    state_d = DECEL;
                    div_d   = div_up;
                    ramp_d  = (ramp_q == 32'd0) ? 32'd0 : ramp_q - 32'd1;
                    cnt_d   = div_up;
                end else if ((state_q == ACCEL) && ({1'b0, div_q} >= ACC_FLOOR)) begin
                    div_d  = div_q - T_STEP;
                    ramp_d = ramp_q + 32'd1;
                    cnt_d  = div_q - T_STEP;
                end else begin
                    if (state_q == ACCEL) state_d = CRUISE;
                    cnt_d = div_q;
                end
            end
        end
    end

    assign bus.step  = step_q;
    assign bus.dir   = dir_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.div   = div_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_step_ramp_seq.sv
// Bench for step_ramp_seq: directed profile scenarios plus randomized moves
// checked against a step-level profile model.
module tb_step_ramp_seq;

  logic clk = 1'b0;
  logic xres = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_ramp_seq_if ia ();
  step_ramp_seq_if ib ();
  logic [1:0] state_a, state_b;

  step_ramp_seq #(.DIV_START(32'd10), .DIV_MIN(32'd4), .T_STEP(32'd2)) dut_a (
    .clk(clk), .xres(xres), .bus(ia), .state_dbg(state_a)
  );
  step_ramp_seq #(.DIV_START(32'd5), .DIV_MIN(32'd5), .T_STEP(32'd2)) dut_b (
    .clk(clk), .xres(xres), .bus(ib), .state_dbg(state_b)
  );

  logic        sel = 1'b0;
  logic        start_drv = 1'b0;
  logic        stop_drv = 1'b0;
  logic        dir_drv = 1'b0;
  logic [31:0] steps_drv = '0;

  assign ia.start  = start_drv & ~sel;
  assign ia.stop   = stop_drv & ~sel;
  assign ia.dir_in = dir_drv;
  assign ia.steps  = steps_drv;
  assign ib.start  = start_drv & sel;
  assign ib.stop   = stop_drv & sel;
  assign ib.dir_in = dir_drv;
  assign ib.steps  = steps_drv;

  logic        o_step, o_dir, o_busy, o_done;
  logic [31:0] o_div;
  assign o_step = sel ? ib.step : ia.step;
  assign o_dir  = sel ? ib.dir  : ia.dir;
  assign o_busy = sel ? ib.busy : ia.busy;
  assign o_done = sel ? ib.done : ia.done;
  assign o_div  = sel ? ib.div  : ia.div;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_div_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Step-level profile: the interval before each step and the period loaded after it.
  task automatic build_model(input int n, input int stop_after, input int ds, input int dm, input int ts);
    int period, remain, ramp, rn, phase;
    bit pend;
    exp_q.delete();
    exp_div_q.delete();
    period = ds; remain = n; ramp = 0; phase = 0; pend = 0;
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back(period);
      rn = remain - 1;
      if (pend) begin
        if (ramp < rn) rn = ramp;
        pend = 0;
      end
      if (rn == 0) begin
        exp_div_q.push_back(period);
        break;
      end
      if (phase == 2 || rn <= ramp) begin
        phase = 2;
        period = (period + ts > ds) ? ds : period + ts;
        ramp = (ramp > 0) ? ramp - 1 : 0;
      end else if (phase == 0 && period >= dm + ts) begin
        period = period - ts;
        ramp++;
      end else begin
        phase = 1;
      end
      exp_div_q.push_back(period);
      remain = rn;
      if (i == stop_after) pend = 1;
    end
  endtask

  task automatic run_move(input bit which, input int n, input bit d, input int stop_after,
                          input bit noise, output int done_rel, output int nsteps);
    int e0, last, cnt, nexp, ds;
    logic [31:0] cur_div, e;
    bit got_done;
    ds = which ? 5 : 10;
    build_model(n, stop_after, ds, which ? 5 : 4, 2);
    nexp = exp_q.size();
    @(negedge clk);
    sel = which; steps_drv = n; dir_drv = d; start_drv = 1'b1; stop_drv = 1'b0;
    @(negedge clk);
    e0 = cyc; start_drv = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_div", o_div, ds);
    last = e0; cur_div = ds; cnt = 0; got_done = 0;
    for (int w = 0; w < 2000 && !got_done; w++) begin
      @(negedge clk);
      start_drv = 1'b0; stop_drv = 1'b0;
      if (o_step) begin
        cnt++;
        if (exp_q.size() == 0) begin
          check("extra_step", cnt, nexp);
        end else begin
          e = exp_q.pop_front();
          check("step_interval", cyc - last, e);
          e = exp_div_q.pop_front();
          check("step_div", o_div, e);
        end
        check("step_dir", o_dir, d);
        last = cyc; cur_div = o_div;
        if (cnt == stop_after) stop_drv = 1'b1;
      end else begin
        check("div_hold", o_div, cur_div);
      end
      if (o_done) begin
        got_done = 1;
        check("done_with_step", o_step, 1);
        check("done_busy_low", o_busy, 0);
        check("step_count", cnt, nexp);
      end else if (noise) begin
        start_drv = ($urandom_range(0, 4) == 0);
        steps_drv = $urandom_range(0, 3);
      end
    end
    check("move_done_seen", got_done, 1);
    done_rel = last - e0;
    nsteps = cnt;
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
  endtask

  int rel, ns;

  initial begin
    xres = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_step", ia.step, 0);
    check("rst_dir", ia.dir, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_done", ia.done, 0);
    check("rst_div_a", ia.div, 10);
    check("rst_div_b", ib.div, 5);
    check("rst_state", state_a, 0);
    xres = 1'b1;
    repeat (2) @(negedge clk);

    // Normal six-step move
    run_move(0, 6, 0, 0, 0, rel, ns);
    check("normal_done_at", rel, 42);
    check("normal_steps", ns, 6);

    // Stop during cruise entry region: clamped decel
    run_move(0, 100, 1, 4, 0, rel, ns);
    check("stop_done_at", rel, 56);
    check("stop_steps", ns, 8);

    // Zero-length move
    @(negedge clk);
    sel = 0; steps_drv = 0; start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    check("zero_done", ia.done, 1);
    check("zero_step", ia.step, 0);
    check("zero_busy", ia.busy, 0);
    @(negedge clk);
    check("zero_done_once", ia.done, 0);

    // Stop while idle must not leak into the next move; starts while busy are ignored
    stop_drv = 1'b1;
    repeat (3) @(negedge clk);
    stop_drv = 1'b0;
    run_move(0, 6, 0, 0, 1, rel, ns);
    check("idle_stop_done_at", rel, 42);

    // Asynchronous reset mid-move
    @(negedge clk);
    sel = 0; steps_drv = 6; dir_drv = 1; start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_rst_busy", ia.busy, 1);
    xres = 1'b0;
    #1;
    check("abort_step", ia.step, 0);
    check("abort_dir", ia.dir, 0);
    check("abort_busy", ia.busy, 0);
    check("abort_done", ia.done, 0);
    check("abort_div", ia.div, 10);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", ia.done, 0);
    end
    xres = 1'b1;
    run_move(0, 6, 1, 0, 0, rel, ns);
    check("post_rst_done_at", rel, 42);

    // Flat profile: DIV_START equals DIV_MIN
    run_move(1, 3, 0, 0, 0, rel, ns);
    check("flat_done_at", rel, 15);

    // Randomized moves on both instances
    for (int r = 0; r < 14; r++) begin
      int n, sa;
      bit which;
      which = (r % 4 == 3);
      n = $urandom_range(1, 16);
      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      run_move(which, n, $urandom_range(0, 1), sa, $urandom_range(0, 1), rel, ns);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
